// File: rtl/gfx_cpu_port.sv
`default_nettype none
// ============================================================================
// Module   : gfx_cpu_port
// Purpose  : Host-bus port for the graphics adapter. Synchronises the
//            asynchronous 8-bit CPU bus into the system clock domain, holds
//            the register file, keeps an auto-incrementing VRAM pointer and
//            buffers pixel writes in a small FIFO that drains to the screen
//            RAM write port through a ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_cpu_port #(
    parameter int ADDR_W     = 16,  // VRAM pointer / RAM address width (9..16)
    parameter int RS_W       = 4,   // register-select width, 2**RS_W >= 8
    parameter int FIFO_DEPTH = 4    // write FIFO entries, power of two, 2..128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_cs_n,
    input  logic                    bus_strobe,
    input  logic                    bus_we_n,
    input  logic [RS_W-1:0]         bus_rs,
    input  logic [7:0]              bus_din,
    output logic [7:0]              bus_dout,
    output logic                    bus_oe,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [7:0]              ram_data,
    output logic                    ram_we,
    input  logic                    ram_ready,
    output logic [(2**RS_W)*8-1:0]  cfg_regs
);

    localparam int NUM_REGS = 2**RS_W;
    localparam int IDX_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = IDX_W + 1;
    localparam int ENT_W    = ADDR_W + 8;

    localparam logic [RS_W-1:0] REG_CTRL    = RS_W'(0);
    localparam logic [RS_W-1:0] REG_DATA    = RS_W'(1);
    localparam logic [RS_W-1:0] REG_ADDR_LO = RS_W'(2);
    localparam logic [RS_W-1:0] REG_ADDR_HI = RS_W'(3);
    localparam logic [RS_W-1:0] REG_STRIDE  = RS_W'(4);
    localparam logic [RS_W-1:0] REG_STATUS  = RS_W'(5);

    // ------------------------------------------------------------------
    // Bus synchronisation and access-edge detection
    // ------------------------------------------------------------------
    logic [1:0]       cs_sync_q;
    logic [1:0]       strobe_sync_q;
    logic             act_s;
    logic             act_q;
    logic             act_rise;
    logic             commit_q;
    logic [RS_W-1:0]  cap_rs_q;
    logic [7:0]       cap_din_q;

    // Two-flop synchronisers; reset to the idle bus state (deselected, no strobe)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q     <= 2'b11;
            strobe_sync_q <= 2'b00;
        end else begin
            cs_sync_q     <= {cs_sync_q[0], bus_cs_n};
            strobe_sync_q <= {strobe_sync_q[0], bus_strobe};
        end
    end

    assign act_s    = ~cs_sync_q[1] & strobe_sync_q[1];
    assign act_rise = act_s & ~act_q;

    // Capture select/data on the synchronised access edge; writes commit one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= 1'b0;
            commit_q  <= 1'b0;
            cap_rs_q  <= '0;
            cap_din_q <= 8'h00;
        end else begin
            act_q    <= act_s;
            commit_q <= act_rise & ~bus_we_n;
            if (act_rise) begin
                cap_rs_q  <= bus_rs;
                cap_din_q <= bus_din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr_data;
    logic wr_lo;
    logic wr_hi;
    logic wr_status;
    logic wr_plain;

    assign wr_data   = commit_q && (cap_rs_q == REG_DATA);
    assign wr_lo     = commit_q && (cap_rs_q == REG_ADDR_LO);
    assign wr_hi     = commit_q && (cap_rs_q == REG_ADDR_HI);
    assign wr_status = commit_q && (cap_rs_q == REG_STATUS);
    // Pointer bytes and STATUS live outside the plain byte array
    assign wr_plain  = commit_q && !wr_lo && !wr_hi && !wr_status;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [LVL_W-1:0] count_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Full/empty come from the pre-cycle level, so a push while full is dropped even with a pop
    assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = wr_data & ~fifo_full;
    assign pop        = ~fifo_empty & ram_ready;

    // ------------------------------------------------------------------
    // Register file, pointer and overflow flag
    // ------------------------------------------------------------------
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [ADDR_W-1:0] stride_ext;
    logic [15:0]       ptr_ext;

    assign stride_ext = ADDR_W'(regs_q[REG_STRIDE]);
    assign ptr_ext    = 16'(ptr_q);

    // Next-state for plain registers: byte-wide write of the captured data
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_plain) begin
            regs_d[cap_rs_q] = cap_din_q;
        end
    end

    // Next-state for pointer: byte loads win, otherwise step after an accepted push
    always_comb begin
        ptr_d = ptr_q;
        if (wr_lo) begin
            ptr_d = {ptr_q[ADDR_W-1:8], cap_din_q};
        end else if (wr_hi) begin
            // Truncation drops din bits above the pointer width
            ptr_d = ADDR_W'({cap_din_q, ptr_q[7:0]});
        end else if (push && regs_q[REG_CTRL][0]) begin
            ptr_d = regs_q[REG_CTRL][1] ? (ptr_q - stride_ext) : (ptr_q + stride_ext);
        end
    end

    // Next-state for sticky overflow: set by a dropped push, cleared by any STATUS write
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (wr_data && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // State registers for the register file, pointer and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 4) ? 8'h01 : 8'h00;
            end
            ptr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    // FIFO storage holds {address, data}; no reset needed since the level guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx_q] <= {ptr_q, cap_din_q};
        end
    end

    // FIFO indices and level; simultaneous push and pop leaves the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head     = mem_q[rd_idx_q];
    assign ram_addr = head[ENT_W-1:8];
    assign ram_data = head[7:0];
    assign ram_we   = ~fifo_empty;

    // ------------------------------------------------------------------
    // Bus read side: combinational from the raw pins
    // ------------------------------------------------------------------
    assign bus_oe = rst_n & ~bus_cs_n & bus_strobe & bus_we_n;

    // Read mux on the raw register select
    always_comb begin
        bus_dout = regs_q[bus_rs];
        case (bus_rs)
            REG_DATA:    bus_dout = 8'(count_q);
            REG_ADDR_LO: bus_dout = ptr_ext[7:0];
            REG_ADDR_HI: bus_dout = ptr_ext[15:8];
            REG_STATUS:  bus_dout = {5'b00000, ovf_q, fifo_full, fifo_empty};
            default:     bus_dout = regs_q[bus_rs];
        endcase
    end

    // Flat copy of the register file; pointer bytes are live, STATUS slot stays zero
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        if (g == 2) begin : g_lo
            assign cfg_regs[8*g +: 8] = ptr_ext[7:0];
        end else if (g == 3) begin : g_hi
            assign cfg_regs[8*g +: 8] = ptr_ext[15:8];
        end else begin : g_byte
            assign cfg_regs[8*g +: 8] = regs_q[g];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gfx_cpu_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_cpu_port
// Purpose  : Self-checking bench for gfx_cpu_port with a transaction-level
//            model of the register map, pointer and RAM write stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_cpu_port;

    localparam int ADDR_W = 16;
    localparam int RS_W   = 4;
    localparam int DEPTH  = 4;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bus_cs_n, bus_strobe, bus_we_n;
    logic [RS_W-1:0]   bus_rs;
    logic [7:0]        bus_din, bus_dout;
    logic              bus_oe;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              ram_ready = 1'b0;
    logic [NREG*8-1:0] cfg_regs;

    always #5 clk = ~clk;

    gfx_cpu_port #(.ADDR_W(ADDR_W), .RS_W(RS_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_cs_n(bus_cs_n), .bus_strobe(bus_strobe), .bus_we_n(bus_we_n),
        .bus_rs(bus_rs), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_ready(ram_ready), .cfg_regs(cfg_regs)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_ctrl, m_stride;
    logic [7:0]  m_scr [NREG];
    logic [15:0] m_ptr;
    bit          m_ov;
    logic [23:0] exp_q [$];   // RAM writes still expected, in order
    logic [23:0] log_q [$];   // RAM writes observed
    int          ready_mode = 0; // 0 low, 1 high, 2 toggle, 3 random

    function automatic void model_reset();
        m_ctrl = 8'h00; m_stride = 8'h01; m_ptr = 16'h0000; m_ov = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NREG; i++) m_scr[i] = 8'h00;
    endfunction

    function automatic void model_write(input logic [3:0] rs, input logic [7:0] d);
        case (rs)
            4'd0: m_ctrl = d;
            4'd1: begin
                if (exp_q.size() >= DEPTH) m_ov = 1'b1;
                else begin
                    exp_q.push_back({m_ptr, d});
                    if (m_ctrl[0]) m_ptr = m_ctrl[1] ? m_ptr - {8'h00, m_stride}
                                                     : m_ptr + {8'h00, m_stride};
                end
            end
            4'd2: m_ptr[7:0]  = d;
            4'd3: m_ptr[15:8] = d;
            4'd4: m_stride = d;
            4'd5: m_ov = 1'b0;
            default: m_scr[rs] = d;
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] rs);
        case (rs)
            4'd0: return m_ctrl;
            4'd1: return 8'(exp_q.size());
            4'd2: return m_ptr[7:0];
            4'd3: return m_ptr[15:8];
            4'd4: return m_stride;
            4'd5: return {5'b0, m_ov, exp_q.size() == DEPTH, exp_q.size() == 0};
            default: return m_scr[rs];
        endcase
    endfunction

    // ---------------- RAM-side monitor and ready driver ----------------
    initial begin
        bit          hold;
        logic [23:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_we", ram_we, 1'b1);
                    chk("hold_entry", {ram_addr, ram_data}, held);
                end
                chk("spurious_we", ram_we && (exp_q.size() == 0), 1'b0);
                case (ready_mode)
                    0: ram_ready = 1'b0;
                    1: ram_ready = 1'b1;
                    2: ram_ready = ~ram_ready;
                    default: ram_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (ram_we && ram_ready && exp_q.size() != 0) begin
                    chk("ram_entry", {ram_addr, ram_data}, exp_q[0]);
                    log_q.push_back({ram_addr, ram_data});
                    void'(exp_q.pop_front());
                end
                hold = ram_we && !ram_ready;
                held = {ram_addr, ram_data};
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wait_room();
        int n = 0;
        while (exp_q.size() >= DEPTH && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("room_timeout", exp_q.size(), DEPTH - 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic bus_write(input logic [3:0] rs, input logic [7:0] d);
        if (rs == 4'd1 && ready_mode != 0) wait_room();
        model_write(rs, d);
        @(posedge clk); #2;
        bus_rs = rs; bus_din = d; bus_we_n = 1'b0; bus_cs_n = 1'b0;
        @(posedge clk); #2;
        bus_strobe = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("oe_write", bus_oe, 1'b0);
        #1 bus_strobe = 1'b0;
        @(posedge clk); #2;
        bus_cs_n = 1'b1; bus_we_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic bus_check(input string name, input logic [3:0] rs, input logic [7:0] exp);
        @(posedge clk); #2;
        bus_rs = rs; bus_we_n = 1'b1; bus_cs_n = 1'b0;
        @(posedge clk); #2;
        bus_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk({name, "_oe"}, bus_oe, 1'b1);
        chk(name, bus_dout, exp);
        repeat (2) @(posedge clk);
        #2 bus_strobe = 1'b0;
        @(posedge clk); #2;
        bus_cs_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_cfg();
        logic [7:0] e;
        for (int i = 0; i < NREG; i++) begin
            if (i != 1 && i != 5) begin
                e = model_read(4'(i));
                chk($sformatf("cfg%0d", i), cfg_regs[8*i +: 8], e);
            end
        end
    endtask

    task automatic chk_log(input int idx, input logic [23:0] exp);
        if (log_q.size() > idx) chk($sformatf("log%0d", idx), log_q[idx], exp);
        else chk($sformatf("log%0d_missing", idx), log_q.size(), idx + 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] reset_vals [6];
        logic [3:0] rs;
        logic [7:0] d;
        int         op;
        reset_vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

        rst_n = 1'b0; bus_cs_n = 1'b1; bus_strobe = 1'b0; bus_we_n = 1'b1;
        bus_rs = '0; bus_din = '0;
        model_reset();

        // Reset state, including bus_oe forced low with an active read on the pins
        repeat (2) @(posedge clk);
        #2 bus_cs_n = 1'b0; bus_strobe = 1'b1;
        #1 chk("oe_in_reset", bus_oe, 1'b0);
        chk("we_in_reset", ram_we, 1'b0);
        chk("cfg_reset", cfg_regs, 128'h1 << 32);
        chk("model_reset_status", model_read(4'd5), 8'h01);
        bus_cs_n = 1'b1; bus_strobe = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 6; i++) bus_check($sformatf("reset_reg%0d", i), 4'(i), reset_vals[i]);

        // Basic auto-increment writes with ready held high
        ready_mode = 1;
        log_q.delete();
        bus_write(4'd2, 8'h34);
        bus_write(4'd3, 8'h12);
        bus_write(4'd0, 8'h01);
        bus_write(4'd1, 8'hAA);
        bus_write(4'd1, 8'hBB);
        wait_drain();
        chk_log(0, 24'h1234AA);
        chk_log(1, 24'h1235BB);
        bus_check("ptr_lo_1236", 4'd2, 8'h36);
        bus_check("ptr_hi_1236", 4'd3, 8'h12);

        // Overflow with ready held low
        ready_mode = 0;
        log_q.delete();
        repeat (2) @(posedge clk);
        for (int i = 0; i < DEPTH + 1; i++) bus_write(4'd1, 8'(8'hC0 + i));
        bus_check("status_full_ovf", 4'd5, 8'h06);
        bus_check("level_full", 4'd1, 8'h04);
        bus_check("ptr_lo_after_ovf", 4'd2, 8'h3A);
        chk("model_ptr_after_ovf", m_ptr, 16'h123A);
        ready_mode = 1;
        wait_drain();
        for (int i = 0; i < DEPTH; i++) chk_log(i, {16'(16'h1236 + i), 8'(8'hC0 + i)});
        chk("ovf_log_count", log_q.size(), DEPTH);
        bus_check("status_empty_ovf", 4'd5, 8'h05);
        bus_write(4'd5, 8'h00);
        bus_check("status_cleared", 4'd5, 8'h01);

        // Decrement with stride 2 across the wrap point
        log_q.delete();
        bus_write(4'd0, 8'h03);
        bus_write(4'd4, 8'h02);
        bus_write(4'd2, 8'h01);
        bus_write(4'd3, 8'h00);
        bus_write(4'd1, 8'h11);
        bus_write(4'd1, 8'h22);
        wait_drain();
        chk_log(0, 24'h000111);
        chk_log(1, 24'hFFFF22);
        bus_check("ptr_lo_fffd", 4'd2, 8'hFD);
        bus_check("ptr_hi_fffd", 4'd3, 8'hFF);
        check_cfg();

        // Push stream with ready toggling every cycle
        ready_mode = 2;
        log_q.delete();
        bus_write(4'd0, 8'(($urandom_range(0, 1) << 1) | 1));
        bus_write(4'd4, 8'($urandom_range(1, 8)));
        for (int i = 0; i < 12; i++) bus_write(4'd1, 8'($urandom));
        wait_drain();
        chk("stream_count", log_q.size(), 12);

        // Random register traffic with random ready
        ready_mode = 3;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            rs = 4'($urandom);
            d  = 8'($urandom);
            if (op == 0) begin
                bus_write(rs, d);
            end else if (op == 1) begin
                if (rs == 4'd1 || rs == 4'd5) rs = 4'd6;
                bus_check($sformatf("rand_read_rs%0d", rs), rs, model_read(rs));
            end else begin
                bus_write(4'd1, d);
            end
            if (n % 10 == 9) check_cfg();
        end
        wait_drain();
        bus_check("rand_final_status", 4'd5, model_read(4'd5));

        // Reset with entries queued and an access in progress
        ready_mode = 0;
        repeat (2) @(posedge clk);
        bus_write(4'd0, 8'h01);
        for (int i = 0; i < 3; i++) bus_write(4'd1, 8'(8'h70 + i));
        bus_check("level_before_reset", 4'd1, 8'h03);
        @(posedge clk); #2;
        bus_rs = 4'd6; bus_din = 8'h5A; bus_we_n = 1'b0; bus_cs_n = 1'b0;
        @(posedge clk); #2 bus_strobe = 1'b1;
        @(posedge clk); #3 rst_n = 1'b0;
        model_reset();
        #1 chk("we_drop_on_reset", ram_we, 1'b0);
        repeat (2) @(posedge clk);
        #2 bus_strobe = 1'b0; bus_cs_n = 1'b1; bus_we_n = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("we_after_reset", ram_we, 1'b0);
        bus_check("status_after_reset", 4'd5, 8'h01);
        bus_check("scratch_no_commit", 4'd6, 8'h00);
        bus_check("level_after_reset", 4'd1, 8'h00);
        bus_check("stride_after_reset", 4'd4, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
